// File: rtl/pic_ack_sequencer_pkg.sv
// Shared encodings, FSM states and the rotating priority search used by the
// 8259A-style interrupt acknowledge sequencer.
package pic_pkg;

    typedef enum logic [2:0] {
        ROT_AEOI_CLR = 3'b000,
        EOI_NS       = 3'b001,
        EOI_NOP      = 3'b010,
        EOI_SP       = 3'b011,
        ROT_AEOI_SET = 3'b100,
        ROT_NS       = 3'b101,
        SET_PRI      = 3'b110,
        ROT_SP       = 3'b111
    } eoi_cmd_e;

    typedef enum logic [1:0] {IDLE, ACK1, ACK2} state_e;

    typedef struct packed {
        logic       valid;
        logic [2:0] level;
    } prio_t;

    // Walk from the lowest-priority level upward so the last hit is the highest.
    function automatic prio_t rot_prio_encode(input logic [7:0] vec, input logic [2:0] lowest);
        prio_t      res;
        logic [2:0] lvl;
        res = '0;
        for (int i = 0; i < 8; i++) begin
            lvl = lowest - 3'(i);
            if (vec[lvl]) begin
                res.valid = 1'b1;
                res.level = lvl;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/pic_ack_sequencer_if.sv
// CPU-side acknowledge bus: INTA strobe in, INT request and vector byte out.
interface pic_ack_sequencer_if;
    logic       inta_n;
    logic       int_out;
    logic [7:0] vector_out;
    logic       vector_oe;
    logic       ack_busy;

    modport master (output inta_n, input int_out, vector_out, vector_oe, ack_busy);
    modport slave  (input inta_n, output int_out, vector_out, vector_oe, ack_busy);
endinterface

// File: rtl/pic_ack_sequencer_prio.sv
// Combinational rotating priority encoder; rank 0 is the highest-priority level.
module pic_prio_resolver
    import pic_pkg::*;
(
    input  logic [7:0] vec,
    input  logic [2:0] lowest,
    output logic       valid,
    output logic [2:0] level,
    output logic [2:0] rank
);
    prio_t res;

    always_comb begin
        res   = rot_prio_encode(vec, lowest);
        valid = res.valid;
        level = res.level;
        rank  = res.level - lowest - 3'd1;
    end
endmodule

// File: rtl/pic_ack_sequencer.sv
// IRR/ISR ownership, rotating priority and two-pulse INTA sequencing for the PIC.
// Optional poll command is built when PIC_POLL_EN is defined.
module pic_ack_sequencer
    import pic_pkg::*;
#(
    parameter int         SYNC_STAGES  = 2,
    parameter logic [2:0] RESET_LOWEST = 3'd7
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                init_clr,
    input  logic                ltim,
    input  logic                aeoi,
    input  logic [4:0]          vec_base,
    input  logic [7:0]          ir,
    input  logic [7:0]          imr,
    input  logic                eoi_valid,
    input  logic [2:0]          eoi_cmd,
    input  logic [2:0]          eoi_level,
`ifdef PIC_POLL_EN
    input  logic                poll_rd,
    output logic [7:0]          poll_word,
`endif
    pic_ack_sequencer_if.slave  bus,
    output logic [7:0]          irr,
    output logic [7:0]          isr,
    output logic [2:0]          lowest_pri
);
    logic [SYNC_STAGES-1:0][7:0] ir_pipe;
    logic [SYNC_STAGES-1:0]      inta_pipe;
    logic [7:0] ir_s, ir_d, ir_rise;
    logic       inta_s, inta_d, inta_armed, inta_fall, inta_rise;

    state_e     state, state_next;
    logic       ack_take, ack_done, poll_take, ack_spur, rot_aeoi;
    logic [2:0] ack_lvl;
    logic       int_q, vec_oe_q;
    logic [7:0] vec_q;

    logic [7:0] cand, isr_set, irr_clr, eoi_clr, aeoi_clr;
    logic       win_valid, isr_valid, req, eoi_rot;
    logic [2:0] win_lvl, win_rank, isr_lvl, isr_rank, eoi_rot_lvl;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ir_pipe   <= '0;
            inta_pipe <= '0;
            ir_d      <= '0;
            inta_d    <= 1'b0;
        end else begin
            ir_pipe   <= {ir_pipe[SYNC_STAGES-2:0], ir};
            inta_pipe <= {inta_pipe[SYNC_STAGES-2:0], bus.inta_n};
            ir_d      <= ir_s;
            inta_d    <= inta_s;
        end
    end

    assign ir_s      = ir_pipe[SYNC_STAGES-1];
    assign inta_s    = inta_pipe[SYNC_STAGES-1];
    assign ir_rise   = ir_s & ~ir_d;
    // A falling edge only counts once inta_n has been seen high since reset/init.
    assign inta_fall = inta_d & ~inta_s & inta_armed;
    assign inta_rise = inta_s & ~inta_d;

    assign cand = irr & ~imr;

    pic_prio_resolver u_cand_res (
        .vec(cand), .lowest(lowest_pri), .valid(win_valid), .level(win_lvl), .rank(win_rank)
    );
    pic_prio_resolver u_isr_res (
        .vec(isr), .lowest(lowest_pri), .valid(isr_valid), .level(isr_lvl), .rank(isr_rank)
    );

    assign req = win_valid && (!isr_valid || (win_rank < isr_rank));

    always_comb begin
        state_next = state;
        ack_take   = 1'b0;
        ack_done   = 1'b0;
        case (state)
            IDLE: if (inta_fall) begin
                state_next = ACK1;
                ack_take   = 1'b1;
            end
            ACK1: if (inta_fall) state_next = ACK2;
            ACK2: if (inta_rise) begin
                state_next = IDLE;
                ack_done   = 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        isr_set  = '0;
        irr_clr  = '0;
        aeoi_clr = '0;
        if ((ack_take || poll_take) && win_valid) begin
            isr_set[win_lvl] = 1'b1;
            irr_clr[win_lvl] = 1'b1;
        end
        if (ack_done && aeoi && !ack_spur) aeoi_clr[ack_lvl] = 1'b1;
    end

    // EOI targets come from the pre-cycle ISR so a coincident ACK1 set is not seen.
    always_comb begin
        eoi_clr     = '0;
        eoi_rot     = 1'b0;
        eoi_rot_lvl = eoi_level;
        if (eoi_valid) begin
            case (eoi_cmd)
                EOI_NS, ROT_NS: if (isr_valid) begin
                    eoi_clr[isr_lvl] = 1'b1;
                    eoi_rot          = (eoi_cmd == ROT_NS);
                    eoi_rot_lvl      = isr_lvl;
                end
                EOI_SP, ROT_SP: if (isr[eoi_level]) begin
                    eoi_clr[eoi_level] = 1'b1;
                    eoi_rot            = (eoi_cmd == ROT_SP);
                end
                SET_PRI: eoi_rot = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n || init_clr) begin
            state      <= IDLE;
            irr        <= '0;
            isr        <= '0;
            lowest_pri <= RESET_LOWEST;
            rot_aeoi   <= 1'b0;
            ack_lvl    <= '0;
            ack_spur   <= 1'b0;
            inta_armed <= 1'b0;
            int_q      <= 1'b0;
            vec_q      <= '0;
            vec_oe_q   <= 1'b0;
        end else begin
            state      <= state_next;
            inta_armed <= inta_armed | inta_s;
            irr        <= ltim ? ir_s : ((irr & ~irr_clr) | ir_rise);
            isr        <= (isr & ~eoi_clr & ~aeoi_clr) | isr_set;
            int_q      <= req & ~ack_take & ~poll_take;
            if (ack_take) begin
                ack_lvl  <= win_valid ? win_lvl : 3'd7;
                ack_spur <= ~win_valid;
            end
            if (state == ACK1 && state_next == ACK2) vec_q <= {vec_base, ack_lvl};
            vec_oe_q <= (state_next == ACK2);
            if (eoi_valid && eoi_cmd == ROT_AEOI_SET) rot_aeoi <= 1'b1;
            else if (eoi_valid && eoi_cmd == ROT_AEOI_CLR) rot_aeoi <= 1'b0;
            // An explicit OCW2 rotate outranks an auto-EOI rotate in the same cycle.
            if (eoi_rot) lowest_pri <= eoi_rot_lvl;
            else if (ack_done && aeoi && !ack_spur && rot_aeoi) lowest_pri <= ack_lvl;
        end
    end

`ifdef PIC_POLL_EN
    assign poll_take = poll_rd & int_q & ~ack_take;

    always_ff @(posedge clk) begin
        if (!reset_n || init_clr) poll_word <= '0;
        else if (poll_rd)         poll_word <= {int_q, 4'b0000, win_lvl};
    end
`else
    assign poll_take = 1'b0;
`endif

    assign bus.int_out    = int_q;
    assign bus.vector_out = vec_q;
    assign bus.vector_oe  = vec_oe_q;
    assign bus.ack_busy   = (state != IDLE);
endmodule

// File: tb/tb_pic_ack_sequencer.sv
// Randomized and directed bench for pic_ack_sequencer against a transaction-level PIC model.
module tb_pic_ack_sequencer;
    localparam int SYNC   = 2;
    localparam int SETTLE = SYNC + 4;

    logic       clk = 1'b0, reset_n = 1'b0, init_clr = 1'b0, ltim = 1'b0, aeoi = 1'b0;
    logic [4:0] vec_base = 5'h08;
    logic [7:0] ir = '0, imr = '0;
    logic       eoi_valid = 1'b0;
    logic [2:0] eoi_cmd = '0, eoi_level = '0;
    logic [7:0] irr, isr;
    logic [2:0] lowest_pri;

    pic_ack_sequencer_if bus ();

    pic_ack_sequencer #(.SYNC_STAGES(SYNC), .RESET_LOWEST(3'd7)) dut (
        .clk(clk), .reset_n(reset_n), .init_clr(init_clr), .ltim(ltim), .aeoi(aeoi),
        .vec_base(vec_base), .ir(ir), .imr(imr), .eoi_valid(eoi_valid),
        .eoi_cmd(eoi_cmd), .eoi_level(eoi_level), .bus(bus),
        .irr(irr), .isr(isr), .lowest_pri(lowest_pri)
    );

    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0;

    // Reference state
    logic [7:0] m_irr, m_isr;
    int         m_low;
    bit         m_rot;

    function automatic int hi_lvl(logic [7:0] v, int low);
        for (int k = 1; k <= 8; k++) if (v[(low + k) % 8]) return (low + k) % 8;
        return -1;
    endfunction

    function automatic int rnk(int lvl, int low);
        return (lvl - low + 7) % 8;
    endfunction

    function automatic logic m_int();
        int w, h;
        w = hi_lvl(m_irr & ~imr, m_low);
        h = hi_lvl(m_isr, m_low);
        return (w >= 0) && (h < 0 || rnk(w, m_low) < rnk(h, m_low));
    endfunction

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0; bus.inta_n = 1'b1; ir = '0; eoi_valid = 1'b0; init_clr = 1'b0;
        tick(2);
        @(negedge clk) reset_n = 1'b1;
        m_irr = '0; m_isr = '0; m_low = 7; m_rot = 1'b0;
        tick(SETTLE);
    endtask

    task automatic set_ir(logic [7:0] v);
        @(negedge clk);
        if (ltim) m_irr = v;
        else      m_irr = m_irr | (v & ~ir);
        ir = v;
        tick(SETTLE);
    endtask

    task automatic send_eoi(logic [2:0] cmd, logic [2:0] lvl);
        int h;
        h = hi_lvl(m_isr, m_low);
        @(negedge clk); eoi_valid = 1'b1; eoi_cmd = cmd; eoi_level = lvl;
        @(negedge clk); eoi_valid = 1'b0;
        case (cmd)
            3'b001, 3'b101: if (h >= 0) begin
                m_isr[h] = 1'b0;
                if (cmd == 3'b101) m_low = h;
            end
            3'b011, 3'b111: if (m_isr[lvl]) begin
                m_isr[lvl] = 1'b0;
                if (cmd == 3'b111) m_low = int'(lvl);
            end
            3'b110: m_low = int'(lvl);
            3'b100: m_rot = 1'b1;
            3'b000: m_rot = 1'b0;
            default: ;
        endcase
        tick(2);
    endtask

    task automatic do_ack();
        int w; logic [2:0] lvl; bit spur;
        w = hi_lvl(m_irr & ~imr, m_low);
        spur = (w < 0);
        lvl = spur ? 3'd7 : 3'(w);
        @(negedge clk) bus.inta_n = 1'b0;
        if (!spur) begin
            m_isr[lvl] = 1'b1;
            if (!ltim) m_irr[lvl] = 1'b0;
        end
        tick(SETTLE);
        vectors++;
        if ({bus.ack_busy, bus.vector_oe} !== 2'b10) begin
            miscompares++;
            $display("FAIL ack1_state: busy/oe=%b expected 10", {bus.ack_busy, bus.vector_oe});
        end
        @(negedge clk) bus.inta_n = 1'b1;
        tick(SETTLE);
        @(negedge clk) bus.inta_n = 1'b0;
        tick(SETTLE);
        vectors++;
        if ({bus.vector_oe, bus.vector_out} !== {1'b1, vec_base, lvl}) begin
            miscompares++;
            $display("FAIL ack2_vector: oe/vec=%b/%h expected 1/%h", bus.vector_oe, bus.vector_out, {vec_base, lvl});
        end
        @(negedge clk) bus.inta_n = 1'b1;
        if (aeoi && !spur) begin
            m_isr[lvl] = 1'b0;
            if (m_rot) m_low = int'(lvl);
        end
        tick(SETTLE);
        vectors++;
        if ({bus.ack_busy, bus.vector_oe} !== 2'b00) begin
            miscompares++;
            $display("FAIL ack_end_state: busy/oe=%b expected 00", {bus.ack_busy, bus.vector_oe});
        end
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if ({irr, isr, lowest_pri} !== {8'h00, 8'h00, 3'd7}) begin
            miscompares++;
            $display("FAIL reset_regs: irr/isr/low=%h/%h/%0d expected 00/00/7", irr, isr, lowest_pri);
        end
        vectors++;
        if ({bus.int_out, bus.vector_out, bus.vector_oe, bus.ack_busy} !== 11'h0) begin
            miscompares++;
            $display("FAIL reset_bus: int/vec/oe/busy=%b/%h/%b/%b expected all 0",
                     bus.int_out, bus.vector_out, bus.vector_oe, bus.ack_busy);
        end
    endtask

    task automatic test_latency();
        int n;
        do_reset();
        ltim = 1'b0; imr = '0; vec_base = 5'h08;
        @(negedge clk) ir = 8'h08;
        m_irr = 8'h08;
        n = 0;
        // count the first sampling edge plus SYNC+1 more
        do begin @(posedge clk); #1; n++; end while (bus.int_out !== 1'b1 && n < 20);
        vectors++;
        if (n !== SYNC + 2) begin
            miscompares++;
            $display("FAIL int_latency: got %0d edges expected %0d", n, SYNC + 2);
        end
        do_ack();
        vectors++;
        if ({bus.vector_out, isr, irr[3]} !== {8'h43, 8'h08, 1'b0}) begin
            miscompares++;
            $display("FAIL ack_ir3: vec/isr/irr3=%h/%h/%b expected 43/08/0", bus.vector_out, isr, irr[3]);
        end
    endtask

    task automatic test_nesting();
        set_ir(8'h28);
        vectors++;
        if (bus.int_out !== 1'b0) begin
            miscompares++;
            $display("FAIL nest_lower: int=%b expected 0", bus.int_out);
        end
        set_ir(8'h2A);
        vectors++;
        if (bus.int_out !== 1'b1) begin
            miscompares++;
            $display("FAIL nest_higher: int=%b expected 1", bus.int_out);
        end
        do_ack();
        send_eoi(3'b101, 3'd0);
        vectors++;
        if ({isr, lowest_pri} !== {8'h08, 3'd1}) begin
            miscompares++;
            $display("FAIL rot_ns: isr/low=%h/%0d expected 08/1", isr, lowest_pri);
        end
        set_ir(8'h00);
        set_ir(8'h05);
        vectors++;
        if ({irr, bus.int_out} !== {m_irr, m_int()}) begin
            miscompares++;
            $display("FAIL nest_pending: irr/int=%h/%b expected %h/%b", irr, bus.int_out, m_irr, m_int());
        end
        do_ack();
        vectors++;
        if (bus.vector_out[2:0] !== 3'd2) begin
            miscompares++;
            $display("FAIL rotated_winner: lvl=%0d expected 2", bus.vector_out[2:0]);
        end
    endtask

    task automatic test_aeoi();
        do_reset();
        aeoi = 1'b1;
        send_eoi(3'b100, 3'd0);
        set_ir(8'h40);
        do_ack();
        vectors++;
        if ({isr, lowest_pri} !== {8'h00, 3'd6}) begin
            miscompares++;
            $display("FAIL aeoi_rot: isr/low=%h/%0d expected 00/6", isr, lowest_pri);
        end
        aeoi = 1'b0;
    endtask

    task automatic test_spurious();
        do_reset();
        set_ir(8'h08);
        do_ack();
        set_ir(8'h00);
        do_ack();
        vectors++;
        if ({bus.vector_out, isr} !== {8'h47, 8'h08}) begin
            miscompares++;
            $display("FAIL spurious: vec/isr=%h/%h expected 47/08", bus.vector_out, isr);
        end
    endtask

    task automatic test_init_abort();
        bit oe_seen;
        do_reset();
        set_ir(8'h10);
        @(negedge clk) bus.inta_n = 1'b0;
        tick(SETTLE);
        @(negedge clk) bus.inta_n = 1'b1;
        tick(SETTLE);
        vectors++;
        if ({bus.ack_busy, isr} !== {1'b1, 8'h10}) begin
            miscompares++;
            $display("FAIL init_pre: busy/isr=%b/%h expected 1/10", bus.ack_busy, isr);
        end
        @(negedge clk) init_clr = 1'b1;
        @(negedge clk) init_clr = 1'b0;
        tick(1);
        vectors++;
        if ({bus.ack_busy, isr, irr, lowest_pri} !== {1'b0, 8'h00, 8'h00, 3'd7}) begin
            miscompares++;
            $display("FAIL init_clear: busy/isr/irr/low=%b/%h/%h/%0d expected 0/00/00/7",
                     bus.ack_busy, isr, irr, lowest_pri);
        end
        oe_seen = 1'b0;
        @(negedge clk) bus.inta_n = 1'b0;
        repeat (SETTLE) begin @(posedge clk); #1; oe_seen = oe_seen | bus.vector_oe; end
        @(negedge clk) bus.inta_n = 1'b1;
        repeat (SETTLE) begin @(posedge clk); #1; oe_seen = oe_seen | bus.vector_oe; end
        vectors++;
        if ({oe_seen, isr} !== {1'b0, 8'h00}) begin
            miscompares++;
            $display("FAIL init_no_oe: oe_seen/isr=%b/%h expected 0/00", oe_seen, isr);
        end
        do_reset();
    endtask

    task automatic test_level();
        do_reset();
        ltim = 1'b1;
        set_ir(8'h10);
        vectors++;
        if ({irr, bus.int_out} !== {8'h10, 1'b1}) begin
            miscompares++;
            $display("FAIL level_high: irr/int=%h/%b expected 10/1", irr, bus.int_out);
        end
        set_ir(8'h00);
        vectors++;
        if ({irr, bus.int_out} !== {8'h00, 1'b0}) begin
            miscompares++;
            $display("FAIL level_drop: irr/int=%h/%b expected 00/0", irr, bus.int_out);
        end
        @(negedge clk) imr = 8'h10;
        set_ir(8'h10);
        vectors++;
        if ({irr, bus.int_out} !== {8'h10, 1'b0}) begin
            miscompares++;
            $display("FAIL level_mask: irr/int=%h/%b expected 10/0", irr, bus.int_out);
        end
        imr = '0;
        set_ir(8'h00);
        ltim = 1'b0;
    endtask

    task automatic test_random();
        do_reset();
        ltim = 1'b0;
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 3))
                0: set_ir(8'($urandom));
                1: begin @(negedge clk) imr = 8'($urandom) & 8'($urandom); tick(3); end
                2: send_eoi(3'($urandom), 3'($urandom));
                default: begin aeoi = 1'($urandom); do_ack(); end
            endcase
            vectors++;
            if ({irr, isr, lowest_pri, bus.int_out} !== {m_irr, m_isr, 3'(m_low), m_int()}) begin
                miscompares++;
                $display("FAIL random_%0d: irr/isr/low/int=%h/%h/%0d/%b expected %h/%h/%0d/%b",
                         i, irr, isr, lowest_pri, bus.int_out, m_irr, m_isr, m_low, m_int());
            end
        end
        aeoi = 1'b0;
    endtask

    initial begin
        bus.inta_n = 1'b1;
        test_reset();
        test_latency();
        test_nesting();
        test_aeoi();
        test_spurious();
        test_init_abort();
        test_level();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, %0d vectors applied", vectors);
        $fatal(1);
    end
endmodule
